// File: rtl/minterm_sweep_checker_pkg.sv
// Shared types and constants for the minterm sweep checker.
// Holds the sweep state encoding, size helpers and reference masks.
package minterm_sweep_checker_pkg;

    localparam int N_MAX = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DONE
    } state_t;

    function automatic int rows(input int n);
        return 1 << n;
    endfunction

    // 4-input reference function: the PoS mask is the complement of the SoP mask
    localparam logic [15:0] F4_SOP = 16'hE5AB;
    localparam logic [15:0] F4_POS = 16'h1A54;

endpackage

// File: rtl/minterm_eval.sv
// Combinational SoP/PoS evaluation of one truth-table row.
// Used to preload either the first row or the following row.
module minterm_eval #(
    parameter int N    = 4,
    parameter int ROWS = 2 ** N
) (
    input  logic [ROWS-1:0] sop,
    input  logic [ROWS-1:0] pos,
    input  logic [N-1:0]    row,
    output logic            sope,
    output logic            pose,
    output logic            mismatch
);

    // A present maxterm forces the PoS output low on its row
    assign sope     = sop[row];
    assign pose     = ~pos[row];
    assign mismatch = sope ^ pose;

endmodule

// File: rtl/minterm_sweep_checker.sv
// Sweeps all rows of an N-input function and streams SoP/PoS values.
// Counts ones and disagreements over a valid/ready handshake.
module minterm_sweep_checker
    import minterm_sweep_checker_pkg::*;
#(
    parameter int N    = 4,
    parameter int ROWS = rows(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [ROWS-1:0] sop_mask,
    input  logic [ROWS-1:0] pos_mask,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_row,
    output logic            out_sope,
    output logic            out_pose,
    output logic            out_mismatch,
    output logic            busy,
    output logic            done,
    output logic [N:0]      ones_count,
    output logic [N:0]      mis_count,
    output logic [N-1:0]    first_mis
);

    localparam int CW = N + 1;

    state_t state_q;
    state_t state_d;

    logic [ROWS-1:0] sop_q;
    logic [ROWS-1:0] pos_q;
    logic [ROWS-1:0] ev_sop;
    logic [ROWS-1:0] ev_pos;
    logic [N-1:0]    ev_row;
    logic            ev_sope;
    logic            ev_pose;
    logic            ev_mis;
    logic            hs;
    logic            last;
    logic            launch;

    assign hs     = out_valid & out_ready;
    assign last   = out_row == N'(ROWS - 1);
    assign launch = (state_q == ST_IDLE) & start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_SWEEP;
            ST_SWEEP: if (hs && last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = state_q == ST_SWEEP;
        busy      = state_q == ST_SWEEP;
        done      = state_q == ST_DONE;
    end

    // In IDLE the evaluator sees the live masks at row 0, otherwise the next row
    always_comb begin
        ev_sop = sop_q;
        ev_pos = pos_q;
        ev_row = out_row + N'(1);
        if (state_q == ST_IDLE) begin
            ev_sop = sop_mask;
            ev_pos = pos_mask;
            ev_row = '0;
        end
    end

    minterm_eval #(
        .N    (N),
        .ROWS (ROWS)
    ) u_eval (
        .sop      (ev_sop),
        .pos      (ev_pos),
        .row      (ev_row),
        .sope     (ev_sope),
        .pose     (ev_pose),
        .mismatch (ev_mis)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sop_q        <= '0;
            pos_q        <= '0;
            out_row      <= '0;
            out_sope     <= 1'b0;
            out_pose     <= 1'b0;
            out_mismatch <= 1'b0;
            ones_count   <= '0;
            mis_count    <= '0;
            first_mis    <= '0;
        end else if (launch) begin
            sop_q        <= sop_mask;
            pos_q        <= pos_mask;
            out_row      <= '0;
            out_sope     <= ev_sope;
            out_pose     <= ev_pose;
            out_mismatch <= ev_mis;
            ones_count   <= '0;
            mis_count    <= '0;
            first_mis    <= '0;
        end else if (hs) begin
            ones_count <= ones_count + CW'(out_sope);
            if (out_mismatch) begin
                mis_count <= mis_count + CW'(1);
                if (mis_count == '0) first_mis <= out_row;
            end
            if (!last) begin
                out_row      <= ev_row;
                out_sope     <= ev_sope;
                out_pose     <= ev_pose;
                out_mismatch <= ev_mis;
            end
        end
    end

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Directed bench for minterm_sweep_checker at N=4 and N=1.
// Hand-derived expectations checked with immediate assertions.
module tb_minterm_sweep_checker;
    import minterm_sweep_checker_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] sop_mask;
    logic [15:0] pos_mask;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  out_row;
    logic        out_sope;
    logic        out_pose;
    logic        out_mismatch;
    logic        busy;
    logic        done;
    logic [4:0]  ones_count;
    logic [4:0]  mis_count;
    logic [3:0]  first_mis;

    logic        startb;
    logic [1:0]  sopb;
    logic [1:0]  posb;
    logic        readyb;
    logic        validb;
    logic [0:0]  rowb;
    logic        sopeb;
    logic        poseb;
    logic        misb;
    logic        busyb;
    logic        doneb;
    logic [1:0]  onesb;
    logic [1:0]  miscb;
    logic [0:0]  firstb;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    minterm_sweep_checker #(.N(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .sop_mask     (sop_mask),
        .pos_mask     (pos_mask),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row      (out_row),
        .out_sope     (out_sope),
        .out_pose     (out_pose),
        .out_mismatch (out_mismatch),
        .busy         (busy),
        .done         (done),
        .ones_count   (ones_count),
        .mis_count    (mis_count),
        .first_mis    (first_mis)
    );

    minterm_sweep_checker #(.N(1)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .start        (startb),
        .sop_mask     (sopb),
        .pos_mask     (posb),
        .out_valid    (validb),
        .out_ready    (readyb),
        .out_row      (rowb),
        .out_sope     (sopeb),
        .out_pose     (poseb),
        .out_mismatch (misb),
        .busy         (busyb),
        .done         (doneb),
        .ones_count   (onesb),
        .mis_count    (miscb),
        .first_mis    (firstb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] exp_ones;
        logic [3:0]  exp_row;
        logic        was_hs;
        int          vcnt;

        // rows 0,1,3,5,7,8,10,13,14,15 evaluate to 1
        exp_ones  = 16'hE5AB;
        reset     = 1'b1;
        start     = 1'b0;
        sop_mask  = '0;
        pos_mask  = '0;
        out_ready = 1'b1;
        startb    = 1'b0;
        sopb      = '0;
        posb      = '0;
        readyb    = 1'b1;
        tick();
        tick();
        check("reset_outs",
              {out_valid, busy, done, out_row, out_sope, out_pose,
               out_mismatch, ones_count, mis_count, first_mis}, 0);
        reset = 1'b0;
        tick();
        check("idle_hold", {out_valid, busy, done}, 0);

        // Plain sweep, equivalent masks
        sop_mask = F4_SOP;
        pos_mask = F4_POS;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("t1_first_valid", {out_valid, busy}, 2'b11);
        for (int r = 0; r < 16; r++) begin
            check($sformatf("t1_row%0d", r),
                  {out_valid, out_row, out_sope, out_pose, out_mismatch},
                  {1'b1, 4'(r), exp_ones[r], exp_ones[r], 1'b0});
            tick();
        end
        check("t1_done", {done, out_valid, busy}, 3'b100);
        check("t1_ones", ones_count, 10);
        check("t1_mis", mis_count, 0);
        tick();
        check("t1_done_pulse", done, 0);

        // One planted disagreement at row 2
        pos_mask = 16'h1A50;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("t2_cleared", {ones_count, mis_count}, 0);
        for (int r = 0; r < 16; r++) begin
            if (r == 2)
                check("t2_row2", {out_row, out_sope, out_pose, out_mismatch},
                      {4'd2, 3'b011});
            tick();
        end
        check("t2_done", done, 1);
        check("t2_mis", mis_count, 1);
        check("t2_first", first_mis, 2);
        check("t2_ones", ones_count, 10);
        tick();

        // Backpressure 1,0,0,1
        pos_mask = F4_POS;
        start    = 1'b1;
        tick();
        start   = 1'b0;
        exp_row = '0;
        vcnt    = 0;
        for (int k = 0; k < 100; k++) begin
            if (done) break;
            if (out_valid) begin
                vcnt++;
                check("t3_row", out_row, exp_row);
            end
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            was_hs    = out_valid & out_ready;
            tick();
            if (was_hs) exp_row++;
        end
        out_ready = 1'b1;
        check("t3_done", done, 1);
        check("t3_valid_cycles", vcnt, 32);
        check("t3_rows_accepted", exp_row, 0);
        check("t3_counts", {ones_count, mis_count}, {5'd10, 5'd0});
        tick();

        // Reset mid-sweep at row 7
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        check("t4_row7", {out_valid, out_row}, {1'b1, 4'd7});
        check("t4_partial_ones", ones_count, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4_reset_outs",
              {out_valid, busy, done, out_row, out_sope, out_pose,
               out_mismatch, ones_count, mis_count, first_mis}, 0);
        tick();
        check("t4_stays_idle", {out_valid, busy, done}, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_restart",
              {out_valid, out_row, out_sope, ones_count, mis_count},
              {1'b1, 4'd0, 1'b1, 5'd0, 5'd0});
        repeat (16) tick();
        check("t4_done", {done, ones_count}, {1'b1, 5'd10});
        tick();

        // start and mask change during a sweep
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start    = 1'b1;
        sop_mask = 16'hFFFF;
        tick();
        start = 1'b0;
        check("t5_no_restart", {out_valid, out_row}, {1'b1, 4'd4});
        check("t5_row4_sope", out_sope, 0);
        repeat (12) tick();
        check("t5_done", done, 1);
        check("t5_counts", {ones_count, mis_count}, {5'd10, 5'd0});
        tick();
        check("t5_idle_hold", {out_valid, busy, done, ones_count},
              {3'b000, 5'd10});

        // N=1 instance
        sopb   = 2'b10;
        posb   = 2'b01;
        startb = 1'b1;
        tick();
        startb = 1'b0;
        check("n1_row0", {validb, rowb, sopeb, poseb, misb}, 5'b10000);
        tick();
        check("n1_row1", {validb, rowb, sopeb, poseb, misb}, 5'b11110);
        tick();
        check("n1_done", {doneb, validb}, 2'b10);
        check("n1_counts", {onesb, miscb}, {2'd1, 2'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/minterm_sweep_checker.md
Name: minterm_sweep_checker

Overview:
- Parametrised, sequential successor to the fixed 4-input SoP/PoS function blocks.
- Loads a runtime minterm mask (SoP form) and a maxterm mask (PoS form) for an N-input function.
- Sweeps all 2^N input rows and streams each row with both evaluations over a valid/ready handshake.
- Counts ones and SoP/PoS disagreements; replaces hand-written truth-table benches for equivalence checks.

Parameters:
- N, 4: number of function inputs; legal range 1..6.
- ROWS, 2**N: derived row count; do not override.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- sop_mask  input  ROWS  bit i=1 means minterm i is present (SoP output is 1 at row i).
- pos_mask  input  ROWS  bit i=1 means maxterm i is present (PoS output is 0 at row i).
- out_valid  output  1  current row is presented.
- out_ready  input  1  consumer accepts the row.
- out_row  output  N  input vector of the current row; MSB is the first variable (x).
- out_sope  output  1  SoP value at out_row.
- out_pose  output  1  PoS value at out_row.
- out_mismatch  output  1  out_sope != out_pose for this row.
- busy  output  1  high in SWEEP.
- done  output  1  one-cycle pulse after the last row is accepted.
- ones_count  output  N+1  number of accepted rows with sope=1.
- mis_count  output  N+1  number of accepted rows with a mismatch.
- first_mis  output  N  index of the first mismatching row; valid when mis_count != 0.

Behaviour:
- States: IDLE, SWEEP, DONE.
- Reset (any state, including mid-sweep):
  - Go to IDLE.
  - out_valid, busy, done, out_row, out_sope, out_pose, out_mismatch, ones_count, mis_count, first_mis all = 0.
  - Latched masks cleared.
- IDLE with start=1:
  - Latch sop_mask and pos_mask into internal registers (sop_q, pos_q).
  - Clear ones_count, mis_count and first_mis.
  - Load row 0: out_row=0, out_sope=sop_mask[0], out_pose=~pos_mask[0], out_mismatch=xor of the two.
  - Next cycle: out_valid=1, busy=1, state SWEEP.
  - Latency from start to first valid row is 1 cycle.
- Masks are sampled only at start; later changes to sop_mask/pos_mask have no effect on a sweep in progress.
- SWEEP:
  - out_valid stays 1; all out_* signals hold stable while out_ready=0 (stall of any length).
  - Handshake = out_valid & out_ready. On a handshake:
    - ones_count += out_sope.
    - If out_mismatch: mis_count += 1; if mis_count was 0, first_mis = out_row.
    - If out_row != ROWS-1: load row out_row+1 from sop_q/pos_q in the same edge, so back-to-back rows stream at 1 row/cycle.
    - If out_row == ROWS-1: out_valid=0, busy=0, state DONE.
- DONE: done=1 for exactly one cycle, then IDLE. Counts and first_mis hold until the next start or reset.
- start is ignored in SWEEP and DONE.
- Width rules:
  - Counters are N+1 bits so that ROWS (all ones) is representable with no overflow.
  - out_row increments only in SWEEP and never wraps past ROWS-1.
- Simultaneous reset and start: reset wins.

Decomposition:
- Shared package holds:
  - State enum (IDLE/SWEEP/DONE).
  - N_MAX=6.
  - Helper function rows(n)=2**n.
  - Reference constants for the bench, e.g. F4_SOP=16'hE5AB and F4_POS=16'h1A54.
- Natural sub-module: minterm_eval. It is combinational and maps (sop_q, pos_q, row) to (sope, pose, mismatch). It is reused for the next-row preload.

Test Plan:
- N=4, sop_mask=16'hE5AB, pos_mask=16'h1A54, out_ready=1, start pulse:
  - Rows 0..15 appear on consecutive cycles.
  - sope=pose=1 on rows 0,1,3,5,7,8,10,13,14,15.
  - done pulses 16 cycles after the first valid row.
  - ones_count=10, mis_count=0.
- Same masks with pos_mask=16'h1A50:
  - Row 2 shows sope=0, pose=1, out_mismatch=1.
  - Final mis_count=1, first_mis=2, ones_count=10.
- out_ready toggled 1,0,0,1 repeating:
  - Row values hold stable during each low phase.
  - No row is skipped or duplicated.
  - The sweep finishes in 32 cycles of valid with identical counts.
- Reset asserted at row 7 mid-sweep:
  - Next cycle all outputs are 0 and state is IDLE.
  - A new start re-sweeps from row 0 with counts cleared.
- start pulsed again during SWEEP, and sop_mask changed to 16'hFFFF mid-sweep:
  - No restart occurs.
  - Results still match the masks latched at the original start.
- N=1 instance, sop_mask=2'b10, pos_mask=2'b01:
  - Rows 0 (0/0) and 1 (1/1) are produced.
  - ones_count=1, done pulses after row 1.
